// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM stage and data memory.
// Stores queue in a small FIFO and drain whenever no load needs the shared address port.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CMP_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [2:0]               st_ctrl,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_stall,
    output logic                     DMWr,
    output logic [31:0]              dm_addr,
    output logic [31:0]              dm_din,
    output logic [2:0]               dm_ctrl,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      e_addr [DEPTH];
    logic [31:0]      e_data [DEPTH];
    logic [2:0]       e_ctrl [DEPTH];
    logic [DEPTH-1:0] e_valid;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;

    logic hit;
    logic ld_go;
    logic drain;
    logic enq;

    // Word-granular overlap check against every buffered store; a store entering this cycle is not yet visible.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_valid[i] && (e_addr[i][CMP_W-1:2] == ld_addr[CMP_W-1:2])) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_stall = !rst && ld_valid && hit;
    assign ld_go    = ld_valid && !ld_stall;
    assign drain    = !rst && !ld_go && (cnt != '0);
    assign st_ready = rst || (cnt < CNT_W'(DEPTH));
    assign enq      = st_valid && st_ready;
    assign count    = cnt;
    assign empty    = (cnt == '0);

    always_comb begin
        DMWr    = drain;
        dm_addr = ld_addr;
        dm_din  = '0;
        dm_ctrl = e_ctrl[rd_ptr];
        if (drain) begin
            dm_addr = e_addr[rd_ptr];
            dm_din  = e_data[rd_ptr];
        end
    end

    // Reset wins over enqueue and drain; entry payloads need no reset because e_valid gates them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            e_valid <= '0;
        end else begin
            if (enq) begin
                e_addr[wr_ptr]  <= st_addr;
                e_data[wr_ptr]  <= st_data;
                e_ctrl[wr_ptr]  <= st_ctrl;
                e_valid[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (drain) begin
                e_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue of pending stores plus two byte memories
// (what the DUT wrote, and what has retired in program order) form the reference.
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctrl;
    } store_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_ctrl;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_stall;
    logic        DMWr;
    logic [31:0] dm_addr;
    logic [31:0] dm_din;
    logic [2:0]  dm_ctrl;
    logic [2:0]  count;
    logic        empty;

    store_t     pend[$];
    logic [7:0] dmem [1024];
    logic [7:0] commit_mem [1024];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .CMP_W(10)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ctrl(st_ctrl),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .DMWr(DMWr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_ctrl(dm_ctrl),
        .count(count), .empty(empty)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Byte lanes touched by a store: 000 word, 001/010 halfword, otherwise byte.
    function automatic void lanes(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                                  output logic [3:0] m, output logic [31:0] w);
        case (c)
            3'b000:         begin m = 4'b1111; w = d; end
            3'b001, 3'b010: begin m = a[1] ? 4'b1100 : 4'b0011; w = {2{d[15:0]}}; end
            default:        begin m = 4'b0001 << a[1:0]; w = {4{d[7:0]}}; end
        endcase
    endfunction

    task automatic writeMem(input bit to_commit, input store_t s);
        logic [3:0]  m;
        logic [31:0] w;
        int          base;
        lanes(s.addr, s.data, s.ctrl, m, w);
        base = 4 * int'(s.addr[9:2]);
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                if (to_commit) commit_mem[base + b] = w[8*b +: 8];
                else           dmem[base + b]       = w[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [31:0] w;
        int          base;
        base = 4 * int'(a[9:2]);
        for (int b = 0; b < 4; b++) w[8*b +: 8] = dmem[base + b];
        return w;
    endfunction

    // Program-order view of a word: retired data overlaid with every still-pending store, oldest first.
    function automatic logic [31:0] progWord(input logic [31:0] a);
        logic [31:0] w;
        logic [3:0]  m;
        logic [31:0] d;
        int          base;
        base = 4 * int'(a[9:2]);
        for (int b = 0; b < 4; b++) w[8*b +: 8] = commit_mem[base + b];
        foreach (pend[i]) begin
            if (pend[i].addr[9:2] == a[9:2]) begin
                lanes(pend[i].addr, pend[i].data, pend[i].ctrl, m, d);
                for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
            end
        end
        return w;
    endfunction

    // Monitor: predicts stall/drain from the pending queue, pops on every DUT write.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset_dmwr", 32'(DMWr), 32'd0);
            checkOutput("reset_stall", 32'(ld_stall), 32'd0);
            pend.delete();
        end else begin
            bit exp_stall;
            bit exp_go;
            bit exp_drain;
            exp_stall = 1'b0;
            foreach (pend[i]) if (ld_valid && pend[i].addr[9:2] == ld_addr[9:2]) exp_stall = 1'b1;
            exp_go    = ld_valid && !exp_stall;
            exp_drain = !exp_go && (pend.size() > 0);
            checkOutput("count", 32'(count), 32'(pend.size()));
            checkOutput("empty", 32'(empty), 32'(pend.size() == 0));
            checkOutput("st_ready", 32'(st_ready), 32'(pend.size() < DEPTH));
            checkOutput("ld_stall", 32'(ld_stall), 32'(exp_stall));
            checkOutput("dmwr", 32'(DMWr), 32'(exp_drain));
            if (DMWr === 1'b1) begin
                if (pend.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL drain_empty: got write to 0x%08h, expected no write at %0t", dm_addr, $time);
                end else begin
                    store_t h;
                    store_t got;
                    h = pend.pop_front();
                    checkOutput("drain_addr", dm_addr, h.addr);
                    checkOutput("drain_data", dm_din, h.data);
                    checkOutput("drain_ctrl", 32'(dm_ctrl), 32'(h.ctrl));
                    writeMem(1'b1, h);
                    got = '{dm_addr, dm_din, dm_ctrl};
                    writeMem(1'b0, got);
                end
            end
            if (exp_go) begin
                checkOutput("load_addr", dm_addr, ld_addr);
                checkOutput("load_data", memWord(ld_addr), progWord(ld_addr));
            end
        end
    end

    // One cycle of stimulus; the expected store is queued when the handshake completes.
    task automatic applyStimulus(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic [2:0] sc, input logic lv, input logic [31:0] la,
                                 output bit accepted, output bit stalled);
        rst      = r;
        st_valid = sv;
        st_addr  = sa;
        st_data  = sd;
        st_ctrl  = sc;
        ld_valid = lv;
        ld_addr  = la;
        @(negedge clk);
        #2;
        accepted = sv && (st_ready === 1'b1) && !r;
        stalled  = (ld_stall === 1'b1);
        if (accepted) pend.push_back('{sa, sd, sc});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a, s;
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, a, s);
    endtask

    task automatic sendStore(input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sc,
                             input logic lv, input logic [31:0] la);
        bit a, s;
        int tries;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 20) begin
            applyStimulus(1'b0, 1'b1, sa, sd, sc, lv, la, a, s);
            tries++;
        end
        if (!a) begin
            checks++;
            errors++;
            $display("[TB] FAIL store_timeout: got no accept for 0x%08h, expected accept within 20 cycles", sa);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          acc, stl;
        int          stalls;
        logic [31:0] w, rnd, sa, la, sd;
        logic [2:0]  sc;

        for (int i = 0; i < 1024; i++) begin
            dmem[i]       = 8'h00;
            commit_mem[i] = 8'h00;
        end
        rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_ctrl = '0;
        ld_valid = 1'b0; ld_addr = '0;

        $display("[TB] reset with st_valid held");
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h1234, 3'd0, 1'b0, 32'd0, acc, stl);
        applyStimulus(1'b1, 1'b1, 32'h100, 32'h1234, 3'd0, 1'b0, 32'd0, acc, stl);
        idle(1);
        checkOutput("t1_no_write", memWord(32'h100), 32'h0);

        $display("[TB] single store");
        sendStore(32'h10, 32'hDEADBEEF, 3'b000, 1'b0, 32'd0);
        idle(2);
        checkOutput("t2_mem", memWord(32'h10), 32'hDEADBEEF);

        $display("[TB] fill and backpressure");
        for (int i = 0; i < 4; i++) sendStore(32'(4 * i), 32'hA000_0000 + 32'(i), 3'b000, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b1, 32'h100, 32'h5555_AAAA, 3'b000, 1'b1, 32'h200, acc, stl);
        checkOutput("t3_fifth_held", 32'(acc), 32'd0);
        sendStore(32'h100, 32'h5555_AAAA, 3'b000, 1'b0, 32'd0);
        idle(6);
        checkOutput("t3_fifth_mem", memWord(32'h100), 32'h5555_AAAA);

        $display("[TB] load conflict");
        sendStore(32'h40, 32'h0BAD_F00D, 3'b000, 1'b1, 32'h200);
        sendStore(32'h21, 32'h0000_00A5, 3'b011, 1'b1, 32'h200);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h20, acc, stl);
            if (!stl) break;
            stalls++;
        end
        checkOutput("t4_stall_cycles", 32'(stalls), 32'd2);
        w = memWord(32'h20);
        checkOutput("t4_byte1", 32'(w[15:8]), 32'hA5);

        $display("[TB] enqueue and drain together");
        sendStore(32'h50, 32'h1111_1111, 3'b000, 1'b1, 32'h200);
        sendStore(32'h54, 32'h2222_2222, 3'b000, 1'b1, 32'h200);
        applyStimulus(1'b0, 1'b1, 32'h58, 32'h3333_3333, 3'b000, 1'b0, 32'd0, acc, stl);
        checkOutput("t5_accept", 32'(acc), 32'd1);
        checkOutput("t5_count", 32'(count), 32'd2);
        idle(4);

        $display("[TB] reset mid-drain");
        sendStore(32'h30, 32'hC0C0_0030, 3'b000, 1'b1, 32'h200);
        sendStore(32'h34, 32'hC0C0_0034, 3'b000, 1'b1, 32'h200);
        sendStore(32'h38, 32'hC0C0_0038, 3'b000, 1'b1, 32'h200);
        idle(1);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 32'd0, acc, stl);
        checkOutput("t6_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b1, 32'h30 + 32'(4 * i), acc, stl);
        checkOutput("t6_mem30", memWord(32'h30), 32'hC0C0_0030);
        checkOutput("t6_mem34", memWord(32'h34), 32'h0);
        checkOutput("t6_mem38", memWord(32'h38), 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            rnd = $urandom;
            sc  = (rnd[1:0] == 2'd0) ? 3'b000 : (rnd[1:0] == 2'd1) ? 3'b001 : 3'b011;
            sa  = {$urandom_range(0, 4194303), 10'(0)} | 32'($urandom_range(0, 63));
            if (sc == 3'b000) sa[1:0] = 2'b00;
            if (sc == 3'b001) sa[0]   = 1'b0;
            la  = {$urandom_range(0, 4194303), 10'(0)} | 32'($urandom_range(0, 63));
            sd  = $urandom;
            applyStimulus($urandom_range(0, 99) == 0, rnd[2], sa, sd, sc, rnd[5:4] == 2'b00, la, acc, stl);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
